micro_reg_arbiter: RTL and testbench
====================================

// Module: micro_reg_arbiter
// PURPOSE
//  Shares the microcode register file between NUM_REQ requesters (microsequencer, debug port, ...).
//  Round-robin grants one request at a time and drives the file's two-phase protocol:
//   - EXECUTE1: latch address / write data via the shared write bus.
//   - EXECUTE2: perform the access.
//  Returns read data / write ack to the granted requester. Sits between requesters and micro_reg_file.
// PARAMETERS
//  NUM_REQ     2                 number of requesters, >=2
//  DATA_W      `DATA_WIDTH       register data width
//  ADDR_W      `REG_SPEC_WIDTH   register index width
// PORTS
//  sys_clk      in   1                clock
//  sys_reset_n  in   1                synchronous, active-low reset
//  req_valid    in   NUM_REQ          request pending, per requester
//  req_rw       in   NUM_REQ          per requester: `REG_FILE_READ / `REG_FILE_WRITE
//  req_addr     in   NUM_REQ*ADDR_W   flattened register index, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata    in   NUM_REQ*DATA_W   flattened write data
//  req_ready    out  NUM_REQ          one-hot grant pulse; request accepted this cycle
//  rsp_valid    out  1                one-cycle completion pulse
//  rsp_id       out  clog2(NUM_REQ)   requester index of the completing request
//  rsp_rdata    out  DATA_W           read data (0 for writes)
//  busy         out  1                high in any state other than IDLE
//  rf_cpu_state out  clog2(`CPU_STATES)  to micro_reg_file.cpu_state
//  rf_en        out  1                to micro_reg_file.reg_file_en
//  rf_rw        out  1                to micro_reg_file.reg_file_rw
//  rf_dst       out  4                to micro_reg_file.reg_dst
//  rf_bus       out  DATA_W           to micro_reg_file.shared_write_bus
//  rf_rd_data   in   DATA_W           from micro_reg_file.reg_rd_data
// BEHAVIOUR
//  Reset (sys_reset_n==0 at posedge):
//   - state=IDLE, rr_ptr=0, latched request cleared.
//   - All outputs 0, except rf_cpu_state=`EXECUTE1 and rf_dst=`REG_SEL_MAP.
//   - Reset mid-transaction abandons it: no rsp_valid. A write in SEL/DATA never reaches the file.
//  FSM states: IDLE, SEL, DATA, ACC, RESP.
//   - IDLE: if any req_valid, pick the first valid index at/after rr_ptr (wrapping).
//     req_ready[g]=1 combinationally in this cycle only. Latch rw/addr/wdata/g. rr_ptr<=(g+1)%NUM_REQ. ->SEL.
//     With no valid requests, stay in IDLE and hold rr_ptr.
//   - SEL:  rf_en=1, rf_cpu_state=`EXECUTE1, rf_dst=`REG_SEL_MAP, rf_bus={0,addr}. Write ->DATA, read ->ACC.
//   - DATA: rf_en=1, `EXECUTE1, rf_dst=`REG_WR_DATA_MAP, rf_bus=wdata. ->ACC.
//   - ACC:  rf_en=1, `EXECUTE2, rf_rw=latched rw, rf_bus=0. ->RESP.
//   - RESP: rsp_valid=1, rsp_id=g, rsp_rdata = read ? rf_rd_data : 0
//     (file's read register updated at ACC edge). ->IDLE.
//  Outside SEL/DATA/ACC: rf_en=0 and rf_rw=`REG_FILE_READ.
//  Latency from the grant cycle:
//   - read: rsp_valid 3 cycles later.
//   - write: rsp_valid 4 cycles later, data visible to a following read.
//  Throughput: one request per 4 (read) / 5 (write) cycles; no grant in RESP.
//  Handshake:
//   - Requester holds valid and payload until its req_ready.
//   - Deasserting valid before the grant is legal; the request is simply not seen.
//   - req_valid is sampled only in IDLE.
//   - Response has no backpressure.
//  Simultaneous requests: strict round-robin; the just-granted requester has lowest priority next.
//   No requester waits more than NUM_REQ-1 grants.
//  rr_ptr wrap: NUM_REQ-1 -> 0.
//  Addresses >= `REG_FILE_DEPTH are passed through unchecked.
// STRUCTURE
//  - defines.vh gains MRA_IDLE..MRA_RESP state encodings (3 bits), beside the existing
//    `REG_SEL_MAP, `REG_WR_DATA_MAP, `REG_FILE_READ/WRITE, `EXECUTE1/2.
//  - One sub-module, rr_arbiter: NUM_REQ, inputs req, ptr, enable; outputs one-hot grant, index.
//  - Top: FSM, request latch, rf_* output decode. All outputs decoded from registered state and latch.
// TESTING
//  1 Reset: sys_reset_n=0 for 2 cycles -> all outputs 0, rf_dst=`REG_SEL_MAP, busy=0.
//  2 Req0 write addr 5 data 0xA5A5, then req0 read addr 5:
//    - ready at cycle 0; SEL / DATA / ACC on cycles 1 / 2 / 3; rsp_valid with id=0 on cycle 4.
//    - Read then returns rsp_rdata=0xA5A5, rsp_valid 3 cycles after its grant.
//  3 Req0 and req1 valid every cycle from reset -> grants alternate 0,1,0,1; each rsp_id matches its grant.
//  4 NUM_REQ=3, only req2 valid, then all three -> req2 granted first; then order 0,1,2 (rr_ptr wrapped to 0).
//  5 sys_reset_n low during DATA of a write to addr 3 (old 0x1111) -> no rsp_valid; a later read of addr 3 returns 0x1111.
//  6 req1 valid raised while busy then dropped before IDLE -> never granted, no rsp with id=1.

Source files
------------

// File: rtl/micro_reg_arbiter_pkg.sv
// Shared constants for the microcode register-file arbiter: file protocol
// encodings (register map selectors, CPU execute phases) and FSM states.
package micro_reg_arbiter_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int REG_SPEC_WIDTH = 4;
  localparam int CPU_STATES     = 8;
  localparam int CPU_STATE_W    = $clog2(CPU_STATES);

  localparam logic [CPU_STATE_W-1:0] EXECUTE1 = CPU_STATE_W'(2);
  localparam logic [CPU_STATE_W-1:0] EXECUTE2 = CPU_STATE_W'(3);

  localparam logic [3:0] REG_SEL_MAP     = 4'hE;
  localparam logic [3:0] REG_WR_DATA_MAP = 4'hF;

  localparam logic REG_FILE_READ  = 1'b0;
  localparam logic REG_FILE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    MRA_IDLE = 3'd0,
    MRA_SEL  = 3'd1,
    MRA_DATA = 3'd2,
    MRA_ACC  = 3'd3,
    MRA_RESP = 3'd4
  } mra_state_e;

endpackage

// File: rtl/micro_reg_arbiter_rr.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant and its index; nothing is granted when disabled.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  int unsigned w_idx;
  logic        w_hit;

  always_comb begin
    grant = '0;
    index = '0;
    w_hit = 1'b0;
    w_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = (ptr + k) % NUM_REQ;
      if (enable && !w_hit && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        index        = IDX_W'(w_idx);
        w_hit        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/micro_reg_arbiter.sv
// Arbitrates requesters onto the microcode register file and sequences its
// two-phase (EXECUTE1 select/data, EXECUTE2 access) protocol per request.
module micro_reg_arbiter
  import micro_reg_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = DATA_WIDTH,
  parameter  int ADDR_W  = REG_SPEC_WIDTH,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      sys_clk,
  input  logic                      sys_reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic [CPU_STATE_W-1:0]    rf_cpu_state,
  output logic                      rf_en,
  output logic                      rf_rw,
  output logic [3:0]                rf_dst,
  output logic [DATA_W-1:0]         rf_bus,
  input  logic [DATA_W-1:0]         rf_rd_data
);

  mra_state_e        r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_arb_en;

  // Reset gates the grant so a requester never sees an accept that is discarded.
  assign w_arb_en = (r_state == MRA_IDLE) && sys_reset_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (r_ptr),
    .enable (w_arb_en),
    .grant  (w_grant),
    .index  (w_idx)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      r_state <= MRA_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_rw    <= REG_FILE_READ;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        MRA_IDLE: begin
          if (|w_grant) begin
            r_rw    <= req_rw[w_idx];
            r_addr  <= req_addr[w_idx*ADDR_W +: ADDR_W];
            r_wdata <= req_wdata[w_idx*DATA_W +: DATA_W];
            r_id    <= w_idx;
            r_ptr   <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_state <= MRA_SEL;
          end
        end
        MRA_SEL:  r_state <= (r_rw == REG_FILE_WRITE) ? MRA_DATA : MRA_ACC;
        MRA_DATA: r_state <= MRA_ACC;
        MRA_ACC:  r_state <= MRA_RESP;
        MRA_RESP: r_state <= MRA_IDLE;
        default:  r_state <= MRA_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready    = w_grant;
    rsp_valid    = (r_state == MRA_RESP);
    rsp_id       = (r_state == MRA_RESP) ? r_id : '0;
    rsp_rdata    = ((r_state == MRA_RESP) && (r_rw == REG_FILE_READ)) ? rf_rd_data : '0;
    busy         = (r_state != MRA_IDLE);
    rf_cpu_state = EXECUTE1;
    rf_en        = 1'b0;
    rf_rw        = REG_FILE_READ;
    rf_dst       = REG_SEL_MAP;
    rf_bus       = '0;
    case (r_state)
      MRA_SEL: begin
        rf_en  = 1'b1;
        rf_bus = DATA_W'(r_addr);
      end
      MRA_DATA: begin
        rf_en  = 1'b1;
        rf_dst = REG_WR_DATA_MAP;
        rf_bus = r_wdata;
      end
      MRA_ACC: begin
        rf_en        = 1'b1;
        rf_cpu_state = EXECUTE2;
        rf_rw        = r_rw;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_micro_reg_arbiter.sv
// Bench for micro_reg_arbiter (3 requesters) with a register-file stub and a
// transaction-timeline model that predicts every output on every cycle.
module tb_micro_reg_arbiter;
  import micro_reg_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int IW = 2;

  logic            sys_clk = 1'b0;
  logic            sys_reset_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_rw = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_rdata;
  logic            busy;
  logic [CPU_STATE_W-1:0] rf_cpu_state;
  logic            rf_en;
  logic            rf_rw;
  logic [3:0]      rf_dst;
  logic [DW-1:0]   rf_bus;
  logic [DW-1:0]   rf_rd_data = '0;

  always #5 sys_clk = ~sys_clk;

  micro_reg_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .busy(busy), .rf_cpu_state(rf_cpu_state), .rf_en(rf_en), .rf_rw(rf_rw),
    .rf_dst(rf_dst), .rf_bus(rf_bus), .rf_rd_data(rf_rd_data)
  );

  // Register-file stub: select/data latched in EXECUTE1, access in EXECUTE2.
  logic [3:0]  fs_sel = '0;
  logic [DW-1:0] fs_wd = '0;
  logic [DW-1:0] fs_mem [16] = '{default: '0};

  always @(posedge sys_clk) begin
    if (rf_en && rf_cpu_state == EXECUTE1) begin
      if (rf_dst == REG_SEL_MAP) fs_sel <= rf_bus[3:0];
      else if (rf_dst == REG_WR_DATA_MAP) fs_wd <= rf_bus;
    end else if (rf_en && rf_cpu_state == EXECUTE2) begin
      if (rf_rw == REG_FILE_WRITE) fs_mem[fs_sel] <= fs_wd;
      else rf_rd_data <= fs_mem[fs_sel];
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Expected outputs per cycle slot, filled in when the model issues a grant.
  typedef struct {
    logic [NR-1:0] ready;
    logic          rv;
    logic [IW-1:0] id;
    logic          rd;
    logic [3:0]    raddr;
    logic          busy;
    logic [CPU_STATE_W-1:0] cs;
    logic          en;
    logic          rw;
    logic [3:0]    dst;
    logic [DW-1:0] bus;
  } exp_t;

  function automatic exp_t idle_e();
    exp_t x;
    x.ready = '0; x.rv = 1'b0; x.id = '0; x.rd = 1'b0; x.raddr = '0;
    x.busy = 1'b0; x.cs = EXECUTE1; x.en = 1'b0; x.rw = REG_FILE_READ;
    x.dst = REG_SEL_MAP; x.bus = '0;
    return x;
  endfunction

  exp_t ring [16];
  logic [DW-1:0] m_mem [16] = '{default: '0};
  int   idle_from = 0;
  int   ptr = 0;
  bit   pw = 0;
  int   pw_slot = 0;
  logic [3:0]  pw_a = '0;
  logic [DW-1:0] pw_d = '0;
  int   gq [$];
  int   m_grant_slot = 0;
  int   m_rsp_slot = 0;
  logic [DW-1:0] m_rdata = '0;
  int   dut_rsp_cnt = 0;
  int   dut_rsp1_cnt = 0;
  logic [DW-1:0] dut_rdata = '0;
  logic [NR-1:0] rdy_seen = '0;
  bit   chk_en = 0;

  initial for (int i = 0; i < 16; i++) ring[i] = idle_e();

  always @(negedge sys_clk) begin
    exp_t e;
    exp_t x;
    int g, t, s;
    logic w;
    logic [3:0] a;
    logic [DW-1:0] d, er;
    rdy_seen = req_ready;
    if (chk_en) begin
      s = cyc % 16;
      e = ring[s];
      if (sys_reset_n && cyc >= idle_from && req_valid != '0) begin
        g = -1;
        for (int k = 0; k < NR; k++)
          if (g < 0 && req_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
        e.ready = NR'(1 << g);
        w = req_rw[g];
        a = req_addr[g*AW +: AW];
        d = req_wdata[g*DW +: DW];
        t = cyc + 1;
        x = idle_e(); x.busy = 1; x.en = 1; x.bus = DW'(a);
        ring[t % 16] = x;
        if (w) begin
          t++;
          x = idle_e(); x.busy = 1; x.en = 1; x.dst = REG_WR_DATA_MAP; x.bus = d;
          ring[t % 16] = x;
          pw = 1; pw_slot = t + 1; pw_a = a; pw_d = d;
        end
        x = idle_e(); x.busy = 1; x.en = 1; x.cs = EXECUTE2; x.rw = w;
        ring[(t + 1) % 16] = x;
        x = idle_e(); x.busy = 1; x.rv = 1; x.id = IW'(g); x.rd = !w; x.raddr = a;
        ring[(t + 2) % 16] = x;
        idle_from = t + 3;
        ptr = (g + 1) % NR;
        gq.push_back(g);
        m_grant_slot = cyc;
      end
      er = e.rd ? m_mem[e.raddr] : '0;
      if (e.rv) begin
        m_rsp_slot = cyc;
        m_rdata = er;
      end
      chk("req_ready", 32'(req_ready), 32'(e.ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(er));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("rf_cpu_state", 32'(rf_cpu_state), 32'(e.cs));
      chk("rf_en", 32'(rf_en), 32'(e.en));
      chk("rf_rw", 32'(rf_rw), 32'(e.rw));
      chk("rf_dst", 32'(rf_dst), 32'(e.dst));
      chk("rf_bus", 32'(rf_bus), 32'(e.bus));
      ring[s] = idle_e();
      if (pw && pw_slot == cyc) begin
        m_mem[pw_a] = pw_d;
        pw = 0;
      end
      if (!sys_reset_n) begin
        for (int i = 0; i < 16; i++) ring[i] = idle_e();
        idle_from = cyc + 1;
        ptr = 0;
        pw = 0;
      end
      cyc++;
    end
    if (rsp_valid) begin
      dut_rsp_cnt++;
      if (rsp_id == 2'd1) dut_rsp1_cnt++;
      dut_rdata = rsp_rdata;
    end
  end

  bit [NR-1:0] keep = '0;
  bit          rand_mode = 0;

  task automatic issue(int i, logic w, logic [3:0] a, logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_rw[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic issue_rand(int i);
    issue(i, 1'($urandom_range(1)), 4'($urandom_range(15)), 16'($urandom));
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (rdy_seen[i]) begin
        req_valid[i] = 1'b0;
        if (keep[i]) issue_rand(i);
      end else if (rand_mode && req_valid[i] && $urandom_range(31) == 0) begin
        req_valid[i] = 1'b0;
      end
      if (rand_mode && !req_valid[i] && $urandom_range(3) == 0) issue_rand(i);
    end
  endtask

  task automatic wait_quiet(string nm, int budget);
    int n = 0;
    while ((req_valid != '0 || busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL %s: timeout after %0d cycles, expected idle", nm, n);
    end
  endtask

  task automatic wait_grant(string nm, int i);
    int n = 0;
    do begin
      step();
      n++;
    end while (!rdy_seen[i] && n < 50);
    if (!rdy_seen[i]) begin
      total++; bad++;
      $display("FAIL %s: no grant for requester %0d, expected one", nm, i);
    end
  endtask

  task automatic do_reset();
    sys_reset_n = 1'b0;
    req_valid = '0;
    keep = '0;
    step();
    step();
    sys_reset_n = 1'b1;
  endtask

  int snap, snap1;

  initial begin
    // Reset from time zero, then start the per-cycle model check.
    do_reset();
    chk_en = 1;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dst", 32'(rf_dst), 32'hE);
    chk("reset_state", 32'(rf_cpu_state), 32'd2);
    chk("reset_en", 32'(rf_en), 32'd0);
    chk("reset_rsp", 32'(rsp_valid), 32'd0);

    // Write then read back through requester 0.
    issue(0, 1'b1, 4'd5, 16'hA5A5);
    wait_quiet("t2_write", 40);
    chk("t2_wr_latency", 32'(m_rsp_slot - m_grant_slot), 32'd4);
    issue(0, 1'b0, 4'd5, 16'h0);
    wait_quiet("t2_read", 40);
    chk("t2_rd_latency", 32'(m_rsp_slot - m_grant_slot), 32'd3);
    chk("t2_model_rdata", 32'(m_rdata), 32'hA5A5);
    chk("t2_dut_rdata", 32'(dut_rdata), 32'hA5A5);

    // Two requesters always pending: grants alternate.
    do_reset();
    gq.delete();
    keep = 3'b011;
    issue_rand(0);
    issue_rand(1);
    repeat (24) step();
    keep = '0;
    wait_quiet("t3", 40);
    chk("t3_count", 32'(gq.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) chk("t3_order", 32'(gq[i]), 32'(i % 2));

    // Last requester first, then pointer wraps to 0.
    do_reset();
    gq.delete();
    issue(2, 1'b0, 4'd1, 16'h0);
    wait_grant("t4_first", 2);
    issue_rand(0);
    issue_rand(1);
    issue_rand(2);
    wait_quiet("t4", 60);
    chk("t4_count", 32'(gq.size()), 32'd4);
    chk("t4_g0", 32'(gq[0]), 32'd2);
    chk("t4_g1", 32'(gq[1]), 32'd0);
    chk("t4_g2", 32'(gq[2]), 32'd1);
    chk("t4_g3", 32'(gq[3]), 32'd2);

    // Reset during the DATA phase of a write abandons it.
    issue(0, 1'b1, 4'd3, 16'h1111);
    wait_quiet("t5_setup", 40);
    issue(0, 1'b1, 4'd3, 16'h2222);
    wait_grant("t5_grant", 0);
    step();
    snap = dut_rsp_cnt;
    sys_reset_n = 1'b0;
    step();
    sys_reset_n = 1'b1;
    repeat (8) step();
    chk("t5_no_rsp", 32'(dut_rsp_cnt - snap), 32'd0);
    issue(1, 1'b0, 4'd3, 16'h0);
    wait_quiet("t5_read", 40);
    chk("t5_model_rdata", 32'(m_rdata), 32'h1111);
    chk("t5_dut_rdata", 32'(dut_rdata), 32'h1111);

    // Requester 1 appears only while busy and withdraws before IDLE.
    issue(0, 1'b1, 4'd7, 16'h3C3C);
    wait_grant("t6_grant", 0);
    snap1 = dut_rsp1_cnt;
    issue(1, 1'b0, 4'd7, 16'h0);
    step();
    step();
    req_valid[1] = 1'b0;
    wait_quiet("t6", 40);
    repeat (3) step();
    chk("t6_no_rsp1", 32'(dut_rsp1_cnt - snap1), 32'd0);

    // Randomized traffic from all requesters, including withdrawals.
    do_reset();
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    wait_quiet("random_drain", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
